load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Consumes the ALU result as effective address for RV32I loads/stores; drives a
//  req/gnt/rvalid data-memory bus; returns sign/zero-extended load data or a store ack.
//  Sits directly downstream of the ALU in the execute/memory path, ahead of writeback.
//  One transaction in flight; the core stalls on req_ready=0.
// PARAMETERS
//  N         32   datapath/address width; only 32 is supported (4 byte lanes)
//  MAX_WAIT  255  cycles in REQ+WAIT before timeout error; 1..2^16-1
// PORTS
//  clk         in   1   clock, rising edge
//  rst_n       in   1   asynchronous, active-low reset
//  req_valid   in   1   core presents an operation
//  req_ready   out  1   LSU accepts (high only in IDLE)
//  req_we      in   1   1=store, 0=load
//  req_funct3  in   3   000 B, 001 H, 010 W, 100 BU, 101 HU
//  req_addr    in   N   effective address (ALU result)
//  req_wdata   in   N   store data, value in low bytes
//  mem_req     out  1   bus request, held until mem_gnt
//  mem_gnt     in   1   bus accepts request this cycle
//  mem_we      out  1   bus write enable
//  mem_be      out  4   byte enables
//  mem_addr    out  N   word-aligned address {req_addr[N-1:2],2'b00}
//  mem_wdata   out  N   store data shifted to lane req_addr[1:0]
//  mem_rvalid  in   1   read data valid
//  mem_rdata   in   N   read word
//  rsp_valid   out  1   one-cycle completion pulse
//  rsp_rdata   out  N   extended load data (0 for stores/errors)
//  rsp_err     out  2   00 ok, 01 misaligned, 10 timeout, 11 illegal funct3
// BEHAVIOUR
//  Reset: state IDLE; req_ready=1; mem_req=0, mem_we=0, mem_be=0, mem_addr=0,
//   mem_wdata=0; rsp_valid=0, rsp_rdata=0, rsp_err=00; wait counter=0. Reset
//   mid-transaction aborts it immediately; late mem_gnt/mem_rvalid are ignored in IDLE.
//  FSM IDLE->REQ->(WAIT)->DONE->IDLE; all outputs registered or decoded from state.
//  IDLE: on req_valid: latch we/funct3/addr/wdata. Illegal funct3 (011,11x; any 1xx
//   for stores) -> DONE err=11. Misaligned (H: addr[0]!=0; W: addr[1:0]!=0) -> DONE
//   err=01. Checks: illegal before misaligned. No bus access on error. Else -> REQ.
//  REQ: mem_req=1, address/be/wdata stable until gnt. On mem_gnt: store -> DONE;
//   load -> WAIT, or -> DONE directly if mem_rvalid in the same cycle (data captured).
//  WAIT: mem_req=0; on mem_rvalid capture extended mem_rdata -> DONE.
//  Counter clears on REQ entry, increments each REQ/WAIT cycle; at MAX_WAIT without
//   the awaited event -> DONE err=10 (event wins if coincident). Counter never wraps.
//  DONE: rsp_valid=1 one cycle, rsp_* valid that cycle only -> IDLE. req_ready=0
//   in REQ/WAIT/DONE; req_valid ignored there.
//  Byte enables: B 0001<<a[1:0]; H 0011<<a[1:0]; W 1111. wdata replicated to lanes.
//  Load extend: select lane by a[1:0]; B/H sign-extend bit 7/15; BU/HU zero-extend.
//  Latency: store with same-cycle gnt: accept c0, REQ c1, rsp_valid c2. Load with
//   rvalid one cycle after gnt: rsp_valid c3. Error: rsp_valid c1.
// STRUCTURE
//  lsu_pkg: funct3 encodings, rsp_err codes, state enum {IDLE,REQ,WAIT,DONE}.
//  Sub-module lsu_align (combinational): byte-enable gen, store lane shift, load
//   lane select + extension. FSM, counter, registers in load_store_unit.
// TESTING
//  SW addr 0x104 wdata 0xDEADBEEF, gnt in REQ c1 -> be=1111, mem_addr 0x104,
//   rsp_valid c2, err=00.
//  LB addr 0x203, mem_rdata 0x80FF_FF00 one cycle after gnt -> rsp_rdata
//   0xFFFFFF80; LBU same -> 0x00000080.
//  SH addr 0x102 wdata 0x1234 -> be=1100, mem_wdata 0x12341234; LH addr 0x101 ->
//   err=01 at c1, mem_req never asserts.
//  Load with gnt but no rvalid, MAX_WAIT=8 -> rsp_err=10 after 8 REQ/WAIT cycles,
//   rsp_rdata=0; rvalid on the 8th cycle -> data returned, err=00.
//  rst_n low during WAIT -> all outputs reset values async; later rvalid ignored.
//  funct3=011 load, req_valid held high in REQ -> err=11; no second accept until IDLE.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 sizes, response codes, FSM states.
// Also holds the request legality/alignment checks applied at acceptance.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    // Size code 11 never exists; stores have no unsigned forms, loads only BU/HU.
    function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
        return (f3[1:0] == 2'b11) || (f3[2] && (we || f3[1]));
    endfunction

    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        case (f3[1:0])
            2'b01:   mis = addr_lo[0];
            2'b10:   mis = |addr_lo;
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: byte enables, store data replication, load lane select and extension.
// Purely combinational; no state, no backpressure.
module lsu_align (
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext
);

    logic [31:0] rd_sh;
    logic        sext;

    assign rd_sh = rdata >> {addr_lo, 3'b000};
    assign sext  = ~funct3[2];

    always_comb begin
        be         = 4'b1111;
        wdata_lane = wdata;
        rdata_ext  = rd_sh;
        case (funct3[1:0])
            2'b00: begin
                be         = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
                rdata_ext  = {{24{sext & rd_sh[7]}}, rd_sh[7:0]};
            end
            2'b01: begin
                be         = 4'b0011 << addr_lo;
                wdata_lane = {2{wdata[15:0]}};
                rdata_ext  = {{16{sext & rd_sh[15]}}, rd_sh[15:0]};
            end
            default: begin
                be         = 4'b1111;
                wdata_lane = wdata;
                rdata_ext  = rd_sh;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one transaction in flight over a req/gnt/rvalid data bus.
// Latency: error 1 cycle, store 1+gnt wait, load 1+gnt+rvalid wait; req_ready high only when idle.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int N        = 32,
    parameter int MAX_WAIT = 255
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_we,
    input  logic [2:0]   req_funct3,
    input  logic [N-1:0] req_addr,
    input  logic [N-1:0] req_wdata,
    output logic         mem_req,
    input  logic         mem_gnt,
    output logic         mem_we,
    output logic [3:0]   mem_be,
    output logic [N-1:0] mem_addr,
    output logic [N-1:0] mem_wdata,
    input  logic         mem_rvalid,
    input  logic [N-1:0] mem_rdata,
    output logic         rsp_valid,
    output logic [N-1:0] rsp_rdata,
    output logic [1:0]   rsp_err
);

    localparam logic [15:0] CNT_LAST = 16'(MAX_WAIT - 1);

    lsu_state_e   state_q, state_d;
    logic         we_q, we_d;
    logic [2:0]   funct3_q, funct3_d;
    logic [N-1:0] addr_q, addr_d;
    logic [N-1:0] wdata_q, wdata_d;
    logic [N-1:0] rdata_q, rdata_d;
    logic [1:0]   err_q, err_d;
    logic [15:0]  cnt_q, cnt_d;

    logic [3:0]   be;
    logic [N-1:0] wdata_lane;
    logic [N-1:0] rdata_ext;
    logic [15:0]  cnt_inc;

    lsu_align u_align (
        .funct3     (funct3_q),
        .addr_lo    (addr_q[1:0]),
        .wdata      (wdata_q),
        .rdata      (mem_rdata),
        .be         (be),
        .wdata_lane (wdata_lane),
        .rdata_ext  (rdata_ext)
    );

    assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    rdata_d  = '0;
                    cnt_d    = '0;
                    if (f3_illegal(req_we, req_funct3)) begin
                        err_d   = ERR_ILLEGAL;
                        state_d = ST_DONE;
                    end else if (f3_misaligned(req_funct3, req_addr[1:0])) begin
                        err_d   = ERR_MISALIGN;
                        state_d = ST_DONE;
                    end else begin
                        err_d   = ERR_OK;
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                cnt_d = cnt_inc;
                // A grant on the last allowed cycle still counts; timeout only when nothing arrived.
                if (mem_gnt) begin
                    if (we_q) begin
                        state_d = ST_DONE;
                    end else if (mem_rvalid) begin
                        rdata_d = rdata_ext;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end else if (cnt_q >= CNT_LAST) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = ST_DONE;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_inc;
                if (mem_rvalid) begin
                    rdata_d = rdata_ext;
                    state_d = ST_DONE;
                end else if (cnt_q >= CNT_LAST) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            we_q     <= 1'b0;
            funct3_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= ERR_OK;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    // Bus and response outputs are qualified by state so they read as zero outside their phase.
    assign req_ready = (state_q == ST_IDLE);
    assign mem_req   = (state_q == ST_REQ);
    assign mem_we    = mem_req & we_q;
    assign mem_be    = mem_req ? be : 4'b0000;
    assign mem_addr  = mem_req ? {addr_q[N-1:2], 2'b00} : '0;
    assign mem_wdata = mem_req ? wdata_lane : '0;
    assign rsp_valid = (state_q == ST_DONE);
    assign rsp_rdata = rsp_valid ? rdata_q : '0;
    assign rsp_err   = rsp_valid ? err_q : ERR_OK;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, hand sequences for reset/held-valid,
// and randomized transactions against a byte-level reference model.
module tb_load_store_unit;

    localparam int MAXW = 8;

    logic        clk, rst_n;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        mem_req, mem_gnt, mem_we, mem_rvalid;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;

    int n_chk = 0;
    int n_pass = 0;

    load_store_unit #(.N(32), .MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int          lat;
        logic [31:0] rdata;
        logic [1:0]  err;
        bit          saw_req;
        logic [3:0]  be;
        logic [31:0] maddr;
        logic [31:0] mwd;
        logic        mwe;
    } res_t;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr, wd, rd;
        int          gd, rdd;
        logic [1:0]  e_err;
        logic [3:0]  e_be;
        logic [31:0] e_mwd, e_rdata;
        int          e_lat;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, got, exp);
    endtask

    // Reference: byte-lane arithmetic plus cycle arithmetic on grant/rvalid arrival.
    function automatic res_t model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                   input logic [31:0] wd, input logic [31:0] rd, input int gd, input int rdd);
        res_t e;
        int size, a, g, v;
        bit legal;
        e = '{default: 0};
        size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        legal = (f3[1:0] != 2'd3) && (we ? !f3[2] : !(f3[2] && f3[1]));
        a = int'(addr[1:0]);
        e.lat = 1;
        if (!legal) begin e.err = 2'd3; return e; end
        if (a % size != 0) begin e.err = 2'd1; return e; end
        e.saw_req = 1;
        e.maddr = {addr[31:2], 2'b00};
        e.mwe = we;
        for (int i = 0; i < 4; i++) begin
            e.be[i] = (i >= a) && (i < a + size);
            e.mwd[8*i +: 8] = wd[8*(i % size) +: 8];
        end
        g = gd + 1;
        if (g > MAXW) begin e.err = 2'd2; e.lat = MAXW + 1; return e; end
        if (we) begin e.lat = g + 1; return e; end
        v = g + rdd;
        if (v > MAXW) begin e.err = 2'd2; e.lat = MAXW + 1; return e; end
        e.lat = v + 1;
        for (int b = 0; b < size; b++) e.rdata[8*b +: 8] = rd[8*(a+b) +: 8];
        if (!f3[2] && size < 4 && e.rdata[8*size-1])
            for (int b = size; b < 4; b++) e.rdata[8*b +: 8] = 8'hFF;
        return e;
    endfunction

    // Entered and left #1 after a rising edge with the DUT idle.
    task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] rd, input int gd, input int rdd,
                           output res_t r);
        int reqc, gcyc;
        bit granted;
        r = '{default: 0};
        r.lat = -1;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_addr = $urandom; req_wdata = $urandom;
        reqc = 0; gcyc = 0; granted = 0;
        for (int k = 1; k <= 40; k++) begin
            mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
            if (mem_req) begin
                reqc++;
                r.saw_req = 1; r.be = mem_be; r.maddr = mem_addr; r.mwd = mem_wdata; r.mwe = mem_we;
                if (reqc > gd && !granted) begin mem_gnt = 1'b1; granted = 1; gcyc = k; end
            end
            if (granted && !we && k == gcyc + rdd) begin mem_rvalid = 1'b1; mem_rdata = rd; end
            @(negedge clk);
            if (rsp_valid) begin r.lat = k; r.rdata = rsp_rdata; r.err = rsp_err; end
            @(posedge clk); #1;
            if (r.lat >= 0) break;
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
    endtask

    task automatic compare(input string tag, input logic we, input res_t got, input res_t exp);
        chk({tag, ".lat"}, got.lat, exp.lat);
        chk({tag, ".err"}, {30'd0, got.err}, {30'd0, exp.err});
        chk({tag, ".rdata"}, got.rdata, exp.rdata);
        chk({tag, ".saw_req"}, {31'd0, got.saw_req}, {31'd0, exp.saw_req});
        if (exp.saw_req) begin
            chk({tag, ".be"}, {28'd0, got.be}, {28'd0, exp.be});
            chk({tag, ".maddr"}, got.maddr, exp.maddr);
            chk({tag, ".mwe"}, {31'd0, got.mwe}, {31'd0, exp.mwe});
            if (we) chk({tag, ".mwd"}, got.mwd, exp.mwd);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".req_ready"}, {31'd0, req_ready}, 32'd1);
        chk({tag, ".mem_req"},   {31'd0, mem_req},   32'd0);
        chk({tag, ".mem_we"},    {31'd0, mem_we},    32'd0);
        chk({tag, ".mem_be"},    {28'd0, mem_be},    32'd0);
        chk({tag, ".mem_addr"},  mem_addr,           32'd0);
        chk({tag, ".mem_wdata"}, mem_wdata,          32'd0);
        chk({tag, ".rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        chk({tag, ".rsp_rdata"}, rsp_rdata,          32'd0);
        chk({tag, ".rsp_err"},   {30'd0, rsp_err},   32'd0);
    endtask

    function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wd, input logic [31:0] rd, input int gd, input int rdd,
                                input logic [1:0] e_err, input logic [3:0] e_be, input logic [31:0] e_mwd,
                                input logic [31:0] e_rdata, input int e_lat);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wd = wd; v.rd = rd; v.gd = gd; v.rdd = rdd;
        v.e_err = e_err; v.e_be = e_be; v.e_mwd = e_mwd; v.e_rdata = e_rdata; v.e_lat = e_lat;
        return v;
    endfunction

    vec_t tbl[17];

    initial begin
        res_t r, e;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        int gd, rdd;

        tbl[0]  = mk(1, 3'b010, 32'h104, 32'hDEADBEEF, 32'h0, 0, 0, 2'd0, 4'hF, 32'hDEADBEEF, 32'h0, 2);
        tbl[1]  = mk(0, 3'b000, 32'h203, 32'h0, 32'h80FFFF00, 0, 1, 2'd0, 4'h8, 32'h0, 32'hFFFFFF80, 3);
        tbl[2]  = mk(0, 3'b100, 32'h203, 32'h0, 32'h80FFFF00, 0, 1, 2'd0, 4'h8, 32'h0, 32'h00000080, 3);
        tbl[3]  = mk(1, 3'b001, 32'h102, 32'h00001234, 32'h0, 0, 0, 2'd0, 4'hC, 32'h12341234, 32'h0, 2);
        tbl[4]  = mk(0, 3'b001, 32'h101, 32'h0, 32'h0, 0, 0, 2'd1, 4'h0, 32'h0, 32'h0, 1);
        tbl[5]  = mk(0, 3'b010, 32'h100, 32'h0, 32'h11223344, 2, 0, 2'd0, 4'hF, 32'h0, 32'h11223344, 4);
        tbl[6]  = mk(0, 3'b101, 32'h202, 32'h0, 32'h89AB0000, 0, 1, 2'd0, 4'hC, 32'h0, 32'h000089AB, 3);
        tbl[7]  = mk(0, 3'b001, 32'h202, 32'h0, 32'h89AB0000, 0, 1, 2'd0, 4'hC, 32'h0, 32'hFFFF89AB, 3);
        tbl[8]  = mk(1, 3'b000, 32'h003, 32'h000000AB, 32'h0, 0, 0, 2'd0, 4'h8, 32'hABABABAB, 32'h0, 2);
        tbl[9]  = mk(1, 3'b100, 32'h000, 32'h0, 32'h0, 0, 0, 2'd3, 4'h0, 32'h0, 32'h0, 1);
        tbl[10] = mk(0, 3'b011, 32'h000, 32'h0, 32'h0, 0, 0, 2'd3, 4'h0, 32'h0, 32'h0, 1);
        tbl[11] = mk(1, 3'b010, 32'h102, 32'h0, 32'h0, 0, 0, 2'd1, 4'h0, 32'h0, 32'h0, 1);
        tbl[12] = mk(0, 3'b110, 32'h001, 32'h0, 32'h0, 0, 0, 2'd3, 4'h0, 32'h0, 32'h0, 1);
        tbl[13] = mk(0, 3'b010, 32'h100, 32'h0, 32'h12345678, 0, 99, 2'd2, 4'hF, 32'h0, 32'h0, 9);
        tbl[14] = mk(0, 3'b010, 32'h108, 32'h0, 32'hCAFEF00D, 0, 7, 2'd0, 4'hF, 32'h0, 32'hCAFEF00D, 9);
        tbl[15] = mk(1, 3'b010, 32'h10C, 32'h55AA55AA, 32'h0, 99, 0, 2'd2, 4'hF, 32'h55AA55AA, 32'h0, 9);
        tbl[16] = mk(0, 3'b000, 32'h201, 32'h0, 32'h00007F00, 3, 2, 2'd0, 4'h2, 32'h0, 32'h0000007F, 7);

        rst_n = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
        req_addr = '0; req_wdata = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        #1 rst_n = 1'b0;
        #2 chk_reset("reset");
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors
        foreach (tbl[i]) begin
            run_txn(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd, tbl[i].rd, tbl[i].gd, tbl[i].rdd, r);
            e = '{default: 0};
            e.lat = tbl[i].e_lat; e.err = tbl[i].e_err; e.rdata = tbl[i].e_rdata;
            e.saw_req = (tbl[i].e_err == 2'd0) || (tbl[i].e_err == 2'd2);
            e.be = tbl[i].e_be; e.maddr = {tbl[i].addr[31:2], 2'b00}; e.mwe = tbl[i].we; e.mwd = tbl[i].e_mwd;
            compare($sformatf("vec%0d", i), tbl[i].we, r, e);
        end

        // Asynchronous reset while a load waits for rvalid; late rvalid must be ignored.
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h40;
        @(posedge clk); #1;
        req_valid = 1'b0; mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        @(posedge clk); #1;
        chk("rstwait.mem_req", {31'd0, mem_req}, 32'd0);
        chk("rstwait.req_ready", {31'd0, req_ready}, 32'd0);
        #2 rst_n = 1'b0;
        #1 chk_reset("rstwait");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        mem_rvalid = 1'b1; mem_rdata = 32'hA5A5A5A5; mem_gnt = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("late_rvalid%0d.rsp_valid", k), {31'd0, rsp_valid}, 32'd0);
            chk($sformatf("late_rvalid%0d.mem_req", k), {31'd0, mem_req}, 32'd0);
            @(posedge clk); #1;
            mem_rvalid = 1'b0; mem_gnt = 1'b0;
        end

        // Illegal load with req_valid held: one response, then re-accept only from IDLE.
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b011; req_addr = 32'h10;
        @(negedge clk);
        chk("held_ill.c0_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("held_ill.c1_valid", {31'd0, rsp_valid}, 32'd1);
        chk("held_ill.c1_err", {30'd0, rsp_err}, 32'd3);
        chk("held_ill.c1_ready", {31'd0, req_ready}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("held_ill.c2_valid", {31'd0, rsp_valid}, 32'd0);
        chk("held_ill.c2_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("held_ill.c3_valid", {31'd0, rsp_valid}, 32'd1);
        @(posedge clk); #1;

        // Legal load with req_valid held through REQ: request fields must not be re-latched.
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h80;
        @(posedge clk); #1;
        req_addr = 32'h999;
        @(negedge clk);
        chk("held_req.c1_ready", {31'd0, req_ready}, 32'd0);
        chk("held_req.c1_mem_req", {31'd0, mem_req}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("held_req.c2_addr", mem_addr, 32'h80);
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h00000005;
        @(posedge clk); #1;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        chk("held_req.c3_valid", {31'd0, rsp_valid}, 32'd1);
        chk("held_req.c3_rdata", rsp_rdata, 32'h5);
        chk("held_req.c3_err", {30'd0, rsp_err}, 32'd0);
        @(posedge clk); #1;

        // Randomized transactions against the reference model.
        for (int i = 0; i < 200; i++) begin
            we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) < 8) begin
                case ($urandom_range(0, 4))
                    0: f3 = 3'b000;
                    1: f3 = 3'b001;
                    2: f3 = 3'b010;
                    3: f3 = 3'b100;
                    default: f3 = 3'b101;
                endcase
            end else begin
                f3 = 3'($urandom);
            end
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (f3[1:0] == 2'b10) addr[1:0] = 2'b00;
                if (f3[1:0] == 2'b01) addr[0] = 1'b0;
            end
            if (we) gd = $urandom_range(0, 9);
            else gd = ($urandom_range(0, 7) == 0) ? 10 : $urandom_range(0, 6);
            rdd = ($urandom_range(0, 7) == 0) ? 99 : $urandom_range(0, 4);
            req_wdata = $urandom;
            mem_rdata = $urandom;
            e = model(we, f3, addr, req_wdata, mem_rdata, gd, rdd);
            run_txn(we, f3, addr, req_wdata, mem_rdata, gd, rdd, r);
            compare($sformatf("rnd%0d", i), we, r, e);
            repeat ($urandom_range(0, 2)) begin
                mem_gnt = 1'($urandom); mem_rvalid = 1'($urandom);
                @(posedge clk); #1;
            end
            mem_gnt = 1'b0; mem_rvalid = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
